// File: rtl/axi_mem_master.sv
// AXI4 master that turns a simple request/response port into single-beat writes
// and INCR read bursts, returning every beat through a one-entry response buffer.
module axi_mem_master #(
  parameter int ID_WIDTH   = 4,
  parameter int TXN_ID     = 0,
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  // request port
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_wen_i,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [7:0]              req_len_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] req_wmask_i,
  // response port
  output logic                    resp_valid_o,
  input  logic                    resp_ready_i,
  output logic [DATA_WIDTH-1:0]   resp_rdata_o,
  output logic                    resp_last_o,
  output logic                    resp_err_o,
  // AXI write address
  output logic                    m_axi_awvalid_o,
  input  logic                    m_axi_awready_i,
  output logic [ID_WIDTH-1:0]     m_axi_awid_o,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr_o,
  output logic [7:0]              m_axi_awlen_o,
  output logic [2:0]              m_axi_awsize_o,
  output logic [1:0]              m_axi_awburst_o,
  // AXI write data
  output logic                    m_axi_wvalid_o,
  input  logic                    m_axi_wready_i,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata_o,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb_o,
  output logic                    m_axi_wlast_o,
  // AXI write response
  input  logic                    m_axi_bvalid_i,
  output logic                    m_axi_bready_o,
  input  logic [ID_WIDTH-1:0]     m_axi_bid_i,
  input  logic [1:0]              m_axi_bresp_i,
  // AXI read address
  output logic                    m_axi_arvalid_o,
  input  logic                    m_axi_arready_i,
  output logic [ID_WIDTH-1:0]     m_axi_arid_o,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr_o,
  output logic [7:0]              m_axi_arlen_o,
  output logic [2:0]              m_axi_arsize_o,
  output logic [1:0]              m_axi_arburst_o,
  // AXI read data
  input  logic                    m_axi_rvalid_i,
  output logic                    m_axi_rready_o,
  input  logic [ID_WIDTH-1:0]     m_axi_rid_i,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata_i,
  input  logic [1:0]              m_axi_rresp_i,
  input  logic                    m_axi_rlast_i
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ADDR = 3'd1,
    S_RD_DATA = 3'd2,
    S_WR_AW_W = 3'd3,
    S_WR_RESP = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [7:0]              len_q, len_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0] wmask_q, wmask_d;
  logic                    wen_q, wen_d;
  logic                    arvalid_q, arvalid_d;
  logic                    awvalid_q, awvalid_d;
  logic                    wvalid_q, wvalid_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0]   resp_rdata_q, resp_rdata_d;
  logic                    resp_last_q, resp_last_d;
  logic                    resp_err_q, resp_err_d;

  logic req_hs_s;
  logic ar_hs_s;
  logic aw_hs_s;
  logic w_hs_s;
  logic r_hs_s;
  logic b_hs_s;
  logic unused_id_s;

  // IDs are constant and only one transaction is ever outstanding
  assign unused_id_s = ^{m_axi_bid_i, m_axi_rid_i};

  assign req_ready_o    = (state_q == S_IDLE) && !resp_valid_q;
  assign m_axi_rready_o = (state_q == S_RD_DATA) && (!resp_valid_q || resp_ready_i);
  assign m_axi_bready_o = (state_q == S_WR_RESP) && !resp_valid_q;

  assign req_hs_s = req_valid_i && req_ready_o;
  assign ar_hs_s  = arvalid_q && m_axi_arready_i;
  assign aw_hs_s  = awvalid_q && m_axi_awready_i;
  assign w_hs_s   = wvalid_q && m_axi_wready_i;
  assign r_hs_s   = m_axi_rvalid_i && m_axi_rready_o;
  assign b_hs_s   = m_axi_bvalid_i && m_axi_bready_o;

  assign m_axi_awvalid_o = awvalid_q;
  assign m_axi_awid_o    = ID_WIDTH'(TXN_ID);
  assign m_axi_awaddr_o  = addr_q;
  assign m_axi_awlen_o   = 8'd0;
  assign m_axi_awsize_o  = 3'b011;
  assign m_axi_awburst_o = 2'b01;

  assign m_axi_wvalid_o = wvalid_q;
  assign m_axi_wdata_o  = wdata_q;
  assign m_axi_wstrb_o  = wmask_q;
  assign m_axi_wlast_o  = 1'b1;

  // Bursts start on a beat boundary; single beats keep the exact byte address
  assign m_axi_arvalid_o = arvalid_q;
  assign m_axi_arid_o    = ID_WIDTH'(TXN_ID);
  assign m_axi_araddr_o  = (len_q != 8'd0) ? {addr_q[ADDR_WIDTH-1:3], 3'b000} : addr_q;
  assign m_axi_arlen_o   = len_q;
  assign m_axi_arsize_o  = 3'b011;
  assign m_axi_arburst_o = 2'b01;

  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = resp_rdata_q;
  assign resp_last_o  = resp_last_q;
  assign resp_err_o   = resp_err_q;

  // Next-state, channel valids, beat counter and response buffer
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    len_d        = len_q;
    wdata_d      = wdata_q;
    wmask_d      = wmask_q;
    wen_d        = wen_q;
    arvalid_d    = arvalid_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    cnt_d        = cnt_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_last_d  = resp_last_q;
    resp_err_d   = resp_err_q;

    case (state_q)
      S_IDLE: begin
        if (req_hs_s) begin
          addr_d  = req_addr_i;
          len_d   = req_len_i;
          wdata_d = req_wdata_i;
          wmask_d = req_wmask_i;
          wen_d   = req_wen_i;
          if (req_wen_i) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_WR_AW_W;
          end else begin
            arvalid_d = 1'b1;
            state_d   = S_RD_ADDR;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD_ADDR: begin
        if (ar_hs_s) begin
          arvalid_d = 1'b0;
          cnt_d     = 8'd0;
          state_d   = S_RD_DATA;
        end else begin
          state_d = S_RD_ADDR;
        end
      end
      S_RD_DATA: begin
        if (r_hs_s) begin
          cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
          if (m_axi_rlast_i) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_RD_DATA;
          end
        end else begin
          state_d = S_RD_DATA;
        end
      end
      S_WR_AW_W: begin
        // AW and W may complete in either order; each valid drops on its own
        awvalid_d = awvalid_q && !aw_hs_s;
        wvalid_d  = wvalid_q && !w_hs_s;
        if (!awvalid_d && !wvalid_d) begin
          state_d = S_WR_RESP;
        end else begin
          state_d = S_WR_AW_W;
        end
      end
      S_WR_RESP: begin
        if (b_hs_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WR_RESP;
        end
      end
      default: begin
        state_d   = S_IDLE;
        arvalid_d = 1'b0;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
      end
    endcase

    // A new load wins over a same-cycle drain
    if (r_hs_s || b_hs_s) begin
      resp_valid_d = 1'b1;
      if (wen_q) begin
        resp_rdata_d = {DATA_WIDTH{1'b0}};
        resp_last_d  = 1'b1;
        resp_err_d   = (m_axi_bresp_i != 2'b00);
      end else begin
        resp_rdata_d = m_axi_rdata_i;
        resp_last_d  = m_axi_rlast_i;
        resp_err_d   = (m_axi_rresp_i != 2'b00) || (m_axi_rlast_i != (cnt_q == len_q));
      end
    end else if (resp_valid_q && resp_ready_i) begin
      resp_valid_d = 1'b0;
    end else begin
      resp_valid_d = resp_valid_q;
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      addr_q       <= {ADDR_WIDTH{1'b0}};
      len_q        <= 8'd0;
      wdata_q      <= {DATA_WIDTH{1'b0}};
      wmask_q      <= {(DATA_WIDTH/8){1'b0}};
      wen_q        <= 1'b0;
      arvalid_q    <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      cnt_q        <= 8'd0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= {DATA_WIDTH{1'b0}};
      resp_last_q  <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
      wen_q        <= wen_d;
      arvalid_q    <= arvalid_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_last_q  <= resp_last_d;
      resp_err_q   <= resp_err_d;
    end
  end

endmodule

// File: tb/tb_axi_mem_master.sv
// Directed, table-driven bench for axi_mem_master; the bench plays the AXI slave
// and the response consumer, driving at the falling edge.
module tb_axi_mem_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_wen = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [7:0]  req_len = 8'd0;
  logic [63:0] req_wdata = 64'd0;
  logic [7:0]  req_wmask = 8'd0;
  logic        resp_valid, resp_ready = 1'b0, resp_last, resp_err;
  logic [63:0] resp_rdata;
  logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0, wlast;
  logic [3:0]  awid, arid;
  logic [31:0] awaddr, araddr;
  logic [7:0]  awlen, arlen, wstrb;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst;
  logic [63:0] wdata;
  logic        bvalid = 1'b0, bready;
  logic [1:0]  bresp = 2'b00;
  logic        arvalid, arready = 1'b0;
  logic        rvalid = 1'b0, rready, rlast = 1'b0;
  logic [63:0] rdata = 64'd0;
  logic [1:0]  rresp = 2'b00;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  axi_mem_master dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_wen_i(req_wen),
    .req_addr_i(req_addr), .req_len_i(req_len), .req_wdata_i(req_wdata), .req_wmask_i(req_wmask),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_rdata_o(resp_rdata),
    .resp_last_o(resp_last), .resp_err_o(resp_err),
    .m_axi_awvalid_o(awvalid), .m_axi_awready_i(awready), .m_axi_awid_o(awid),
    .m_axi_awaddr_o(awaddr), .m_axi_awlen_o(awlen), .m_axi_awsize_o(awsize), .m_axi_awburst_o(awburst),
    .m_axi_wvalid_o(wvalid), .m_axi_wready_i(wready), .m_axi_wdata_o(wdata),
    .m_axi_wstrb_o(wstrb), .m_axi_wlast_o(wlast),
    .m_axi_bvalid_i(bvalid), .m_axi_bready_o(bready), .m_axi_bid_i(4'd0), .m_axi_bresp_i(bresp),
    .m_axi_arvalid_o(arvalid), .m_axi_arready_i(arready), .m_axi_arid_o(arid),
    .m_axi_araddr_o(araddr), .m_axi_arlen_o(arlen), .m_axi_arsize_o(arsize), .m_axi_arburst_o(arburst),
    .m_axi_rvalid_i(rvalid), .m_axi_rready_o(rready), .m_axi_rid_i(4'd0),
    .m_axi_rdata_i(rdata), .m_axi_rresp_i(rresp), .m_axi_rlast_i(rlast)
  );

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [63:0] data;      // write data, or first read beat (later beats add the index)
    logic [7:0]  wmask;
    logic [1:0]  rsp;       // RRESP / BRESP returned by the slave
    int          last_idx;  // read beat carrying RLAST
    int          aw_d;      // cycles before AWREADY
    int          w_d;       // cycles before WREADY
    logic        bp;        // consumer ready pattern 1,0,0,1
    logic [31:0] exp_addr;
    logic [7:0]  exp_err;   // expected err per response beat
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic timeout(input string name);
    total_cnt++;
    $display("FAIL %s: timed out", name);
  endtask

  // Present a request at the current falling edge and leave once it is accepted
  task automatic issue(input vec_t v);
    int n;
    req_valid = 1'b1; req_wen = v.wen; req_addr = v.addr; req_len = v.len;
    req_wdata = v.data; req_wmask = v.wmask;
    #1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (!req_ready) timeout("req_accept");
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic run_read(input vec_t v);
    int sent, got, cyc;
    logic [3:0] pat;
    pat = 4'b1001;
    #1;
    check("arvalid_rise", 64'(arvalid), 64'd1);
    check("araddr", 64'(araddr), 64'(v.exp_addr));
    check("arlen", 64'(arlen), 64'(v.len));
    check("arsize_burst_id", 64'({arsize, arburst, arid}), 64'({3'b011, 2'b01, 4'd0}));
    @(negedge clk);
    check("arvalid_hold", 64'({arvalid, araddr}), 64'({1'b1, v.exp_addr}));
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    #1;
    check("arvalid_drop", 64'(arvalid), 64'd0);
    sent = 0; got = 0;
    for (cyc = 0; got <= v.last_idx && cyc < 300; cyc++) begin
      rvalid = (sent <= v.last_idx);
      rdata  = v.data + 64'(sent);
      rlast  = (sent == v.last_idx);
      rresp  = v.rsp;
      resp_ready = v.bp ? pat[cyc % 4] : 1'b1;
      #1;
      if (resp_valid && !resp_ready) check("rready_stall", 64'(rready), 64'd0);
      if (resp_valid && resp_ready) begin
        check("rd_data", resp_rdata, v.data + 64'(got));
        check("rd_last", 64'(resp_last), 64'(got == v.last_idx));
        check("rd_err", 64'(resp_err), 64'(v.exp_err[got]));
        got++;
      end
      if (rvalid && rready) sent++;
      @(negedge clk);
    end
    if (got <= v.last_idx) timeout("rd_beats");
    rvalid = 1'b0; rlast = 1'b0; resp_ready = 1'b0;
  endtask

  task automatic run_write(input vec_t v);
    int maxd, n;
    maxd = (v.aw_d > v.w_d) ? v.aw_d : v.w_d;
    #1;
    check("aw_w_same_cycle", 64'({awvalid, wvalid}), 64'(2'b11));
    check("awaddr", 64'(awaddr), 64'(v.exp_addr));
    check("aw_len_size_burst", 64'({awlen, awsize, awburst, awid}), 64'({8'd0, 3'b011, 2'b01, 4'd0}));
    check("wdata", wdata, v.data);
    check("wstrb_wlast", 64'({wstrb, wlast}), 64'({v.wmask, 1'b1}));
    for (int c = 0; c <= maxd; c++) begin
      awready = (c == v.aw_d);
      wready  = (c == v.w_d);
      #1;
      if (c == v.aw_d) check("awvalid_hold", 64'(awvalid), 64'd1);
      if (c == v.w_d) check("wvalid_hold", 64'(wvalid), 64'd1);
      if (c == v.aw_d + 1) check("awvalid_drop_early", 64'(awvalid), 64'd0);
      if (c == v.w_d + 1) check("wvalid_drop_early", 64'(wvalid), 64'd0);
      @(negedge clk);
    end
    awready = 1'b0; wready = 1'b0;
    #1;
    check("aw_w_done", 64'({awvalid, wvalid}), 64'd0);
    n = 0;
    while (!bready && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (!bready) timeout("bready");
    bvalid = 1'b1; bresp = v.rsp;
    @(negedge clk);
    bvalid = 1'b0; bresp = 2'b00;
    #1;
    check("wr_resp_valid", 64'(resp_valid), 64'd1);
    check("wr_rdata", resp_rdata, 64'd0);
    check("wr_last", 64'(resp_last), 64'd1);
    check("wr_err", 64'(resp_err), 64'(v.exp_err[0]));
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    issue(v);
    if (v.wen) run_write(v);
    else run_read(v);
    #1;
    check("idle_after", 64'({req_ready, resp_valid}), 64'(2'b10));
  endtask

  initial begin
    //           wen   addr           len   data                       wmask  rsp    last aw w bp    exp_addr       exp_err
    vecs[0] = '{1'b0, 32'h8000_0004, 8'd0, 64'h1122_3344_5566_7788, 8'h00, 2'd0, 0, 0, 0, 1'b0, 32'h8000_0004, 8'h00};
    vecs[1] = '{1'b0, 32'h8000_0013, 8'd3, 64'hA5A5_0000_0000_0010, 8'h00, 2'd0, 3, 0, 0, 1'b0, 32'h8000_0010, 8'h00};
    vecs[2] = '{1'b0, 32'h8000_020F, 8'd3, 64'h0102_0304_0506_0700, 8'h00, 2'd0, 3, 0, 0, 1'b1, 32'h8000_0208, 8'h00};
    vecs[3] = '{1'b0, 32'h8000_0020, 8'd0, 64'h0000_0000_CAFE_0000, 8'h00, 2'd2, 0, 0, 0, 1'b0, 32'h8000_0020, 8'h01};
    vecs[4] = '{1'b0, 32'h8000_0041, 8'd1, 64'h4141_4141_0000_0000, 8'h00, 2'd0, 0, 0, 0, 1'b0, 32'h8000_0040, 8'h01};
    vecs[5] = '{1'b0, 32'h8000_0080, 8'd1, 64'h8080_0000_0000_0000, 8'h00, 2'd0, 2, 0, 0, 1'b0, 32'h8000_0080, 8'h06};
    vecs[6] = '{1'b1, 32'h8000_1000, 8'd0, 64'hDEAD_BEEF_0000_0000, 8'hF0, 2'd0, 0, 0, 2, 1'b0, 32'h8000_1000, 8'h00};
    vecs[7] = '{1'b1, 32'h8000_1008, 8'd5, 64'h0123_4567_89AB_CDEF, 8'h0F, 2'd2, 0, 3, 1, 1'b0, 32'h8000_1008, 8'h01};
    vecs[8] = '{1'b1, 32'h8000_1010, 8'd0, 64'hFFFF_0000_FFFF_0000, 8'hFF, 2'd0, 0, 0, 0, 1'b0, 32'h8000_1010, 8'h00};
    vecs[9] = '{1'b0, 32'h8000_0007, 8'd0, 64'h7777_6666_5555_4444, 8'h00, 2'd0, 0, 0, 0, 1'b0, 32'h8000_0007, 8'h00};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_valids", 64'({resp_valid, awvalid, wvalid, arvalid, bready, rready}), 64'd0);
    check("rst_resp", 64'({resp_rdata, resp_last, resp_err}), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    @(negedge clk);

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Reset in the middle of a 4-beat burst after two beats
    issue('{1'b0, 32'h8000_0100, 8'd3, 64'h0, 8'h00, 2'd0, 3, 0, 0, 1'b0, 32'h8000_0100, 8'h00});
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    resp_ready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      rvalid = 1'b1; rdata = 64'h100 + 64'(b); rlast = 1'b0;
      #1;
      check("mid_rready", 64'(rready), 64'd1);
      @(negedge clk);
    end
    rvalid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    resp_ready = 1'b0;
    #1;
    check("mid_rst_valids", 64'({resp_valid, awvalid, wvalid, arvalid, bready, rready}), 64'd0);
    check("mid_rst_resp", 64'({resp_rdata, resp_last, resp_err}), 64'd0);
    check("mid_rst_idle", 64'(req_ready), 64'd1);
    @(negedge clk);
    run_vec(vecs[0]);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/axi_mem_master.md
# axi_mem_master

CPU-side AXI4 master that turns simple request/response transactions into AXI4 bursts toward the physical-memory AXI slave. It serves the LSU and I-cache refill paths. Reads may be single-beat or INCR bursts of up to 256 beats. Writes are single-beat with byte strobes. Every response is returned through a one-entry registered buffer with backpressure.

## Interface
- ID_WIDTH, 4, AXI ID width; all IDs driven as constant TXN_ID
- TXN_ID, 0, ID value placed on AWID/ARID
- DATA_WIDTH, 64, data bus width, fixed at 64
- ADDR_WIDTH, 32, address width
- clock  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high reset
- req_valid / req_ready  in/out  1  request handshake
- req_wen  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  byte address
- req_len  in  8  read beats minus one; ignored for writes
- req_wdata  in  64  write data
- req_wmask  in  8  write byte strobes
- resp_valid / resp_ready  out/in  1  response handshake
- resp_rdata  out  64  read beat data; 0 for writes
- resp_last  out  1  final beat of a transaction
- resp_err  out  1  nonzero RRESP/BRESP, or a burst-length protocol error
- M_AXI_AW{VALID out, READY in, ID out, ADDR out, LEN out 8, SIZE out 3, BURST out 2}
- M_AXI_W{VALID out, READY in, DATA out 64, STRB out 8, LAST out}
- M_AXI_B{VALID in, READY out, ID in, RESP in 2}
- M_AXI_AR{VALID out, READY in, ID out, ADDR out, LEN out 8, SIZE out 3, BURST out 2}
- M_AXI_R{VALID in, READY out, ID in, DATA in 64, RESP in 2, LAST in}

## Operation
- FSM states:
  - IDLE → RD_ADDR on an accepted read request.
  - IDLE → WR_AW_W on an accepted write request.
  - RD_ADDR → RD_DATA on the AR handshake.
  - RD_DATA → IDLE on the accepted beat with RLAST.
  - WR_AW_W → WR_RESP once both the AW and W handshakes are done, in either order or the same cycle.
  - WR_RESP → IDLE on the B handshake.
- req_ready = (state == IDLE) && !resp_valid. A new transaction starts only after the previous response has drained.
- On request acceptance, register addr, len, wdata, wmask and wen.
- Read address channel: ARLEN = req_len, ARSIZE = 3'b011, ARBURST = 2'b01 (INCR).
  - If req_len ≠ 0, ARADDR forces bits [2:0] to 0.
  - If req_len = 0, the address passes through unmodified.
- Write: AWLEN = 0, AWSIZE = 3'b011, AWBURST = 2'b01, WLAST = 1.
  - AWVALID and WVALID rise together on entry to WR_AW_W.
  - Each drops independently after its own handshake.
- 8-bit beat counter: cleared on AR handshake, incremented on each R handshake.
- RREADY = (state == RD_DATA) && (!resp_valid || resp_ready).
- Each R handshake loads the buffer:
  - rdata = RDATA
  - last = RLAST
  - err = (RRESP ≠ 0) | (RLAST ≠ (cnt == len))
- Early RLAST ends the transaction, with err set on that beat.
- Missing RLAST at cnt == len sets err on that beat. The FSM keeps accepting beats until RLAST; counter saturates at 255.
- BREADY = (state == WR_RESP) && !resp_valid.
- The B handshake loads the buffer with rdata = 0, last = 1, err = (BRESP ≠ 0).
- resp_valid clears on resp_ready unless a new beat loads in the same cycle; a load has priority.
- BID/RID are ignored (single outstanding transaction).

## Timing
- Reset (synchronous, active-high):
  - state = IDLE
  - resp_valid, AWVALID, WVALID, ARVALID, BREADY, RREADY = 0
  - resp_rdata = 0, resp_last = 0, resp_err = 0, counter = 0
- Reset mid-transaction abandons the transaction. All outputs take reset values the next cycle, and the slave is reset alongside.
- ARVALID / AWVALID / WVALID are registered and assert 1 cycle after req handshake. They hold stable, with payload unchanged, until their own READY.
- Read latency: the first resp_valid appears 1 cycle after the first R handshake.
- Write response: resp_valid appears 1 cycle after the B handshake.
- A continuously ready consumer sustains 1 beat/cycle.
- resp_ready held low stalls RREADY after the buffer fills, with no beat loss.
- AXI VALID never depends combinationally on READY.

## Test plan
- Single read: addr 0x8000_0004, len 0.
  - Expect ARADDR = 0x8000_0004 and ARLEN = 0.
  - Slave returns 0x1122334455667788 with RLAST → one resp: rdata 0x1122334455667788, last = 1, err = 0.
- Burst read: addr 0x8000_0013, len 3.
  - Expect ARADDR = 0x8000_0010 and ARLEN = 3.
  - Four in-order beats, resp_last only on the 4th, err = 0.
- Burst read backpressure: resp_ready toggled 1,0,0,1,…
  - All beats arrive in order with no loss.
  - RREADY is low while the buffer is full and resp_ready = 0.
- Write: addr 0x8000_1000, wdata 0xDEADBEEF_00000000, wmask 0xF0.
  - AW and W issued the same cycle, with STRB = 0xF0 and WLAST = 1.
  - AWREADY arrives 2 cycles before WREADY → single resp: last = 1, err = 0.
- Errors:
  - RRESP = 2 on a single read → err = 1.
  - len 1 with RLAST on beat 0 → err = 1, last = 1, FSM returns to IDLE.
- Reset asserted during RD_DATA after 2 of 4 beats → the next cycle all valids/readies are 0, state is IDLE, and a new request is accepted.
